// File: rtl/mreg_file.sv
// Parametrised DECODE-stage register file: NREAD combinational read ports, two
// write ports with write-to-read bypass, optional hardwired zero register, busy scoreboard.
module mreg_file #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   regwrite,
  input  logic [AW-1:0]          rd,
  input  logic [WIDTH-1:0]       writedata,
  input  logic                   regwrite2,
  input  logic [AW-1:0]          rd2,
  input  logic [WIDTH-1:0]       writedata2,
  input  logic                   reserve,
  input  logic [AW-1:0]          reserve_addr,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*WIDTH-1:0] rdata,
  output logic [NREAD-1:0]       rbusy
);

  localparam bit ZeroEn = (ZERO_REG != 0);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic             we0;
  logic             we1;
  logic             res;
  logic [AW-1:0]    a;

  // Writes and reserves aimed at a hardwired zero register are dropped here.
  assign we0 = regwrite  && !(ZeroEn && (rd == '0));
  assign we1 = regwrite2 && !(ZeroEn && (rd2 == '0));
  assign res = reserve   && !(ZeroEn && (reserve_addr == '0));

  // Port 1 is applied last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (we0) regs[rd]  <= writedata;
      if (we1) regs[rd2] <= writedata2;
    end
  end

  // A new producer reserving a register outranks a write completing to it.
  always_comb begin
    busy_next = busy;
    if (we0) busy_next[rd]           = 1'b0;
    if (we1) busy_next[rd2]          = 1'b0;
    if (res) busy_next[reserve_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    a     = '0;
    for (int i = 0; i < NREAD; i++) begin
      a = raddr[i*AW +: AW];
      if (!rst_n) begin
        rdata[i*WIDTH +: WIDTH] = '0;
      end else if (ZeroEn && (a == '0)) begin
        rdata[i*WIDTH +: WIDTH] = '0;
      end else if (regwrite2 && (rd2 == a)) begin
        rdata[i*WIDTH +: WIDTH] = writedata2;
      end else if (regwrite && (rd == a)) begin
        rdata[i*WIDTH +: WIDTH] = writedata;
      end else begin
        rdata[i*WIDTH +: WIDTH] = regs[a];
        rbusy[i]                = busy[a];
      end
    end
  end

endmodule

// File: tb/tb_mreg_file.sv
// Directed bench for mreg_file: a ZERO_REG=1/NREAD=4 instance and a ZERO_REG=0/NREAD=2
// instance share the write and reserve inputs and are read independently.
module tb_mreg_file;

  logic         clk;
  logic         rst_n;
  logic         regwrite;
  logic [4:0]   rd;
  logic [31:0]  writedata;
  logic         regwrite2;
  logic [4:0]   rd2;
  logic [31:0]  writedata2;
  logic         reserve;
  logic [4:0]   reserve_addr;
  logic [19:0]  raddr;
  logic [127:0] rdata;
  logic [3:0]   rbusy;
  logic [9:0]   raddr_z;
  logic [63:0]  rdata_z;
  logic [1:0]   rbusy_z;

  int total = 0;
  int bad   = 0;

  logic [31:0] vals [9] = '{32'h002300AA, 32'h10654321, 32'h00100022, 32'h8C123456,
                            32'h8F123456, 32'hAD654321, 32'h13012345, 32'hAC654321,
                            32'h12012345};

  mreg_file #(.WIDTH(32), .DEPTH(32), .NREAD(4), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .regwrite(regwrite), .rd(rd), .writedata(writedata),
    .regwrite2(regwrite2), .rd2(rd2), .writedata2(writedata2),
    .reserve(reserve), .reserve_addr(reserve_addr),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy)
  );

  mreg_file #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(0)) dut_z (
    .clk(clk), .rst_n(rst_n),
    .regwrite(regwrite), .rd(rd), .writedata(writedata),
    .regwrite2(regwrite2), .rd2(rd2), .writedata2(writedata2),
    .reserve(reserve), .reserve_addr(reserve_addr),
    .raddr(raddr_z), .rdata(rdata_z), .rbusy(rbusy_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after a falling edge so they are stable around the next rising edge.
  task automatic applyStimulus(input logic we0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic we1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic res, input logic [4:0] ra);
    @(negedge clk);
    regwrite     = we0;
    rd           = a0;
    writedata    = d0;
    regwrite2    = we1;
    rd2          = a1;
    writedata2   = d1;
    reserve      = res;
    reserve_addr = ra;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] rport(input int i);
    return rdata[i*32 +: 32];
  endfunction

  function automatic logic [31:0] zport(input int i);
    return rdata_z[i*32 +: 32];
  endfunction

  initial begin
    rst_n = 1'b0;
    raddr = '0;
    raddr_z = '0;
    regwrite = 1'b0; rd = '0; writedata = '0;
    regwrite2 = 1'b0; rd2 = '0; writedata2 = '0;
    reserve = 1'b0; reserve_addr = '0;

    // Reset state, with a write to register 1 held active that must be ignored.
    #2;
    regwrite = 1'b1; rd = 5'd1; writedata = 32'h55555555;
    raddr[5 +: 5] = 5'd1;
    #1;
    checkOutput("reset_rdata", rport(1), 32'h0);
    checkOutput("reset_rbusy", {31'b0, rbusy[1]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    regwrite = 1'b0;

    for (int k = 0; k < 9; k++)
      applyStimulus(1'b1, 5'(k), vals[k], 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

    // Evens read on port 0, odds on port 1, for both instances.
    for (int k = 0; k < 9; k++) begin
      raddr[(k % 2)*5 +: 5]   = 5'(k);
      raddr_z[(k % 2)*5 +: 5] = 5'(k);
      #1;
      checkOutput($sformatf("fill_z1_r%0d", k), rport(k % 2), (k == 0) ? 32'h0 : vals[k]);
      checkOutput($sformatf("fill_z0_r%0d", k), zport(k % 2), vals[k]);
      checkOutput($sformatf("fill_busy_r%0d", k), {31'b0, rbusy[k % 2]}, 32'h0);
    end

    // Both write ports target register 5; port 1 must win in bypass and in the array.
    applyStimulus(1'b1, 5'd5, 32'h11111111, 1'b1, 5'd5, 32'h22222222, 1'b0, 5'd0);
    raddr[0 +: 5] = 5'd5;
    #1;
    checkOutput("dual_bypass", rport(0), 32'h22222222);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("dual_array", rport(0), 32'h22222222);

    // Reserve 7, then complete it with a port-0 write.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    raddr[5 +: 5] = 5'd7;
    #1;
    checkOutput("resv7_same_cycle", {31'b0, rbusy[1]}, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("resv7_busy", {31'b0, rbusy[1]}, 32'h1);
    checkOutput("resv7_data", rport(1), 32'hAC654321);
    applyStimulus(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("wr7_bypass_busy", {31'b0, rbusy[1]}, 32'h0);
    checkOutput("wr7_bypass_data", rport(1), 32'hDEADBEEF);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("wr7_after_busy", {31'b0, rbusy[1]}, 32'h0);
    checkOutput("wr7_after_data", rport(1), 32'hDEADBEEF);

    // Reserve and write register 3 together: busy must survive the write.
    applyStimulus(1'b1, 5'd3, 32'h33333333, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    raddr[10 +: 5] = 5'd3;
    #1;
    checkOutput("rw3_bypass_data", rport(2), 32'h33333333);
    checkOutput("rw3_bypass_busy", {31'b0, rbusy[2]}, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("rw3_after_busy", {31'b0, rbusy[2]}, 32'h1);
    checkOutput("rw3_after_data", rport(2), 32'h33333333);

    // Reserving register 0 is dropped only when it is hardwired.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    raddr[15 +: 5] = 5'd0;
    raddr_z[0 +: 5] = 5'd0;
    #1;
    checkOutput("resv0_z1_busy", {31'b0, rbusy[3]}, 32'h0);
    checkOutput("resv0_z1_data", rport(3), 32'h0);
    checkOutput("resv0_z0_busy", {31'b0, rbusy_z[0]}, 32'h1);
    checkOutput("resv0_z0_data", zport(0), 32'h002300AA);

    // Every port reading the same register.
    applyStimulus(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    raddr = {4{5'd9}};
    #1;
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("all9_p%0d", i), rport(i), 32'hCAFEF00D);

    // Asynchronous reset mid-cycle with a write to register 10 held active.
    applyStimulus(1'b1, 5'd10, 32'h12345678, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    raddr = {5'd10, 5'd3, 5'd7, 5'd9};
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("async_rst_data_p%0d", i), rport(i), 32'h0);
      checkOutput($sformatf("async_rst_busy_p%0d", i), {31'b0, rbusy[i]}, 32'h0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    regwrite = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("post_rst_r10", rport(3), 32'h0);
    checkOutput("post_rst_r3_busy", {31'b0, rbusy[2]}, 32'h0);
    checkOutput("post_rst_r9", rport(0), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
